// File: rtl/tm_qm_ctrl.sv
// Third-level queue-manager controller: arbitrates enqueue/dequeue and sequences the head/tail/depth/ll/pkt_desc memories.
// Optional: define TM_QM_CTRL_DEPTH1_MIRROR_EN to mirror every depth write onto the depth1 memory.
module tm_qm_ctrl #(
    parameter int unsigned QUEUE_ID_NBITS      = 4,
    parameter int unsigned QUEUE_ENTRIES_NBITS = 4,
    parameter int unsigned PKT_DESC_NBITS      = 32
) (
    input  logic                           clk,
    input  logic                           rstn,
    output logic                           init_done,

    input  logic                           enq_req,
    input  logic [QUEUE_ID_NBITS-1:0]      enq_qid,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] enq_ptr,
    input  logic [PKT_DESC_NBITS-1:0]      enq_desc,
    output logic                           enq_ack,
    output logic                           enq_err,

    input  logic                           deq_req,
    input  logic [QUEUE_ID_NBITS-1:0]      deq_qid,
    output logic                           deq_ack,
    output logic                           deq_valid,
    output logic                           deq_empty,
    output logic [QUEUE_ENTRIES_NBITS-1:0] deq_ptr,
    output logic [PKT_DESC_NBITS-1:0]      deq_desc,

    output logic                           head_wr,
    output logic [QUEUE_ID_NBITS-1:0]      head_raddr,
    output logic [QUEUE_ID_NBITS-1:0]      head_waddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] head_wdata,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] head_rdata,

    output logic                           tail_wr,
    output logic [QUEUE_ID_NBITS-1:0]      tail_raddr,
    output logic [QUEUE_ID_NBITS-1:0]      tail_waddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] tail_wdata,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] tail_rdata,

    output logic                           depth_wr,
    output logic [QUEUE_ID_NBITS-1:0]      depth_raddr,
    output logic [QUEUE_ID_NBITS-1:0]      depth_waddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] depth_wdata,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] depth_rdata,

    output logic                           depth1_wr,
    output logic [QUEUE_ID_NBITS-1:0]      depth1_raddr,
    output logic [QUEUE_ID_NBITS-1:0]      depth1_waddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] depth1_wdata,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] depth1_rdata,

    output logic                           ll_wr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] ll_raddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] ll_waddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] ll_wdata,
    input  logic [QUEUE_ENTRIES_NBITS-1:0] ll_rdata,

    output logic                           pkt_desc_wr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] pkt_desc_raddr,
    output logic [QUEUE_ENTRIES_NBITS-1:0] pkt_desc_waddr,
    output logic [PKT_DESC_NBITS-1:0]      pkt_desc_wdata,
    input  logic [PKT_DESC_NBITS-1:0]      pkt_desc_rdata
);

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_ENQ_WR, ST_DEQ_RD, ST_DEQ_WR} state_t;

    state_t                         state;
    logic [QUEUE_ID_NBITS-1:0]      init_cnt;
    logic                           init_wr;
    logic                           last_enq;
    logic [QUEUE_ID_NBITS-1:0]      qid_q;
    logic [QUEUE_ENTRIES_NBITS-1:0] ptr_q;
    logic [PKT_DESC_NBITS-1:0]      desc_q;
    logic [QUEUE_ENTRIES_NBITS-1:0] head_q;
    logic [QUEUE_ENTRIES_NBITS-1:0] depth_q;
    logic                           grant_enq;
    logic                           grant_deq;
    logic                           unused_depth1_rdata;

    assign unused_depth1_rdata = ^depth1_rdata;

    always_comb begin
        grant_enq = (state == ST_IDLE) && enq_req && (!deq_req || !last_enq);
        grant_deq = (state == ST_IDLE) && deq_req && !grant_enq;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_wr   <= 1'b0;
            init_done <= 1'b0;
            last_enq  <= 1'b0;
            qid_q     <= '0;
            ptr_q     <= '0;
            desc_q    <= '0;
            head_q    <= '0;
            depth_q   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_wr && init_cnt == '1) begin
                        init_wr   <= 1'b0;
                        init_done <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        init_wr <= 1'b1;
                        if (init_wr)
                            init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (grant_enq) begin
                        qid_q    <= enq_qid;
                        ptr_q    <= enq_ptr;
                        desc_q   <= enq_desc;
                        last_enq <= 1'b1;
                        state    <= ST_ENQ_WR;
                    end else if (grant_deq) begin
                        qid_q    <= deq_qid;
                        last_enq <= 1'b0;
                        state    <= ST_DEQ_RD;
                    end
                end
                ST_ENQ_WR: state <= ST_IDLE;
                ST_DEQ_RD: begin
                    if (depth_rdata == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        head_q  <= head_rdata;
                        depth_q <= depth_rdata;
                        state   <= ST_DEQ_WR;
                    end
                end
                ST_DEQ_WR: state <= ST_IDLE;
                default:   state <= ST_INIT;
            endcase
        end
    end

    // Grant, memory-port and result signals are decoded combinationally from the
    // registered state so reads issue in the grant cycle and writes land one cycle later.
    always_comb begin
        enq_ack        = grant_enq;
        deq_ack        = grant_deq;
        enq_err        = 1'b0;
        deq_valid      = 1'b0;
        deq_empty      = 1'b0;
        deq_ptr        = '0;
        deq_desc       = '0;
        head_wr        = 1'b0;
        head_raddr     = '0;
        head_waddr     = '0;
        head_wdata     = '0;
        tail_wr        = 1'b0;
        tail_raddr     = '0;
        tail_waddr     = '0;
        tail_wdata     = '0;
        depth_wr       = init_wr;
        depth_raddr    = '0;
        depth_waddr    = init_cnt;
        depth_wdata    = '0;
        ll_wr          = 1'b0;
        ll_raddr       = '0;
        ll_waddr       = '0;
        ll_wdata       = '0;
        pkt_desc_wr    = 1'b0;
        pkt_desc_raddr = '0;
        pkt_desc_waddr = '0;
        pkt_desc_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (grant_enq) begin
                    tail_raddr  = enq_qid;
                    depth_raddr = enq_qid;
                end else if (grant_deq) begin
                    head_raddr  = deq_qid;
                    depth_raddr = deq_qid;
                end
            end
            ST_ENQ_WR: begin
                if (depth_rdata == '1) begin
                    enq_err = 1'b1;
                end else begin
                    tail_wr        = 1'b1;
                    tail_waddr     = qid_q;
                    tail_wdata     = ptr_q;
                    depth_wr       = 1'b1;
                    depth_waddr    = qid_q;
                    depth_wdata    = depth_rdata + 1'b1;
                    pkt_desc_wr    = 1'b1;
                    pkt_desc_waddr = ptr_q;
                    pkt_desc_wdata = desc_q;
                    if (depth_rdata == '0) begin
                        head_wr    = 1'b1;
                        head_waddr = qid_q;
                        head_wdata = ptr_q;
                    end else begin
                        ll_wr    = 1'b1;
                        ll_waddr = tail_rdata;
                        ll_wdata = ptr_q;
                    end
                end
            end
            ST_DEQ_RD: begin
                if (depth_rdata == '0) begin
                    deq_valid = 1'b1;
                    deq_empty = 1'b1;
                end else begin
                    ll_raddr       = head_rdata;
                    pkt_desc_raddr = head_rdata;
                end
            end
            ST_DEQ_WR: begin
                head_wr     = 1'b1;
                head_waddr  = qid_q;
                head_wdata  = ll_rdata;
                depth_wr    = 1'b1;
                depth_waddr = qid_q;
                depth_wdata = depth_q - 1'b1;
                deq_valid   = 1'b1;
                deq_ptr     = head_q;
                deq_desc    = pkt_desc_rdata;
            end
            default: ;
        endcase
    end

`ifdef TM_QM_CTRL_DEPTH1_MIRROR_EN
    assign depth1_wr    = depth_wr;
    assign depth1_waddr = depth_waddr;
    assign depth1_wdata = depth_wdata;
    assign depth1_raddr = '0;
`else
    assign depth1_wr    = 1'b0;
    assign depth1_waddr = '0;
    assign depth1_wdata = '0;
    assign depth1_raddr = '0;
`endif

endmodule

// File: tb/tb_tm_qm_ctrl.sv
// Directed bench for tm_qm_ctrl with behavioural 1-cycle-read memories and a depth1 mirror monitor.
module tb_tm_qm_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    always #5 clk = ~clk;

    logic        init_done;
    logic        enq_req = 1'b0, enq_ack, enq_err;
    logic [3:0]  enq_qid = '0, enq_ptr = '0;
    logic [15:0] enq_desc = '0;
    logic        deq_req = 1'b0, deq_ack, deq_valid, deq_empty;
    logic [3:0]  deq_qid = '0, deq_ptr;
    logic [15:0] deq_desc;
    logic        head_wr, tail_wr, depth_wr, depth1_wr, ll_wr, pkt_desc_wr;
    logic [3:0]  head_raddr, head_waddr, head_wdata, head_rdata;
    logic [3:0]  tail_raddr, tail_waddr, tail_wdata, tail_rdata;
    logic [3:0]  depth_raddr, depth_waddr, depth_wdata, depth_rdata;
    logic [3:0]  depth1_raddr, depth1_waddr, depth1_wdata;
    logic [3:0]  depth1_rdata = '0;
    logic [3:0]  ll_raddr, ll_waddr, ll_wdata, ll_rdata;
    logic [3:0]  pkt_desc_raddr, pkt_desc_waddr;
    logic [15:0] pkt_desc_wdata, pkt_desc_rdata;

    logic [3:0]  head_mem [16];
    logic [3:0]  tail_mem [16];
    logic [3:0]  depth_mem [16];
    logic [3:0]  ll_mem [16];
    logic [15:0] pd_mem [16];

    logic        bd_depth_wr = 1'b0, bd_tail_wr = 1'b0;
    logic [3:0]  bd_addr = '0, bd_data = '0;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    tm_qm_ctrl #(.QUEUE_ID_NBITS(4), .QUEUE_ENTRIES_NBITS(4), .PKT_DESC_NBITS(16)) dut (
        .clk(clk), .rstn(rstn), .init_done(init_done),
        .enq_req(enq_req), .enq_qid(enq_qid), .enq_ptr(enq_ptr), .enq_desc(enq_desc),
        .enq_ack(enq_ack), .enq_err(enq_err),
        .deq_req(deq_req), .deq_qid(deq_qid), .deq_ack(deq_ack), .deq_valid(deq_valid),
        .deq_empty(deq_empty), .deq_ptr(deq_ptr), .deq_desc(deq_desc),
        .head_wr(head_wr), .head_raddr(head_raddr), .head_waddr(head_waddr),
        .head_wdata(head_wdata), .head_rdata(head_rdata),
        .tail_wr(tail_wr), .tail_raddr(tail_raddr), .tail_waddr(tail_waddr),
        .tail_wdata(tail_wdata), .tail_rdata(tail_rdata),
        .depth_wr(depth_wr), .depth_raddr(depth_raddr), .depth_waddr(depth_waddr),
        .depth_wdata(depth_wdata), .depth_rdata(depth_rdata),
        .depth1_wr(depth1_wr), .depth1_raddr(depth1_raddr), .depth1_waddr(depth1_waddr),
        .depth1_wdata(depth1_wdata), .depth1_rdata(depth1_rdata),
        .ll_wr(ll_wr), .ll_raddr(ll_raddr), .ll_waddr(ll_waddr),
        .ll_wdata(ll_wdata), .ll_rdata(ll_rdata),
        .pkt_desc_wr(pkt_desc_wr), .pkt_desc_raddr(pkt_desc_raddr), .pkt_desc_waddr(pkt_desc_waddr),
        .pkt_desc_wdata(pkt_desc_wdata), .pkt_desc_rdata(pkt_desc_rdata)
    );

    // Registered-read memories; bd_* is a bench backdoor for preloading depth/tail.
    always @(posedge clk) begin
        if (head_wr) head_mem[head_waddr] <= head_wdata;
        if (tail_wr) tail_mem[tail_waddr] <= tail_wdata;
        else if (bd_tail_wr) tail_mem[bd_addr] <= bd_data;
        if (depth_wr) depth_mem[depth_waddr] <= depth_wdata;
        else if (bd_depth_wr) depth_mem[bd_addr] <= bd_data;
        if (ll_wr) ll_mem[ll_waddr] <= ll_wdata;
        if (pkt_desc_wr) pd_mem[pkt_desc_waddr] <= pkt_desc_wdata;
        head_rdata     <= head_mem[head_raddr];
        tail_rdata     <= tail_mem[tail_raddr];
        depth_rdata    <= depth_mem[depth_raddr];
        ll_rdata       <= ll_mem[ll_raddr];
        pkt_desc_rdata <= pd_mem[pkt_desc_raddr];
    end

    always @(negedge clk) begin
        logic [12:0] exp_d1;
        if (mon_en) begin
`ifdef TM_QM_CTRL_DEPTH1_MIRROR_EN
            exp_d1 = {depth_wr, depth_waddr, depth_wdata, 4'd0};
`else
            exp_d1 = '0;
`endif
            checks++;
            if ({depth1_wr, depth1_waddr, depth1_wdata, depth1_raddr} !== exp_d1) begin
                failures++;
                $display("FAIL depth1_mirror t=%0t got=%h exp=%h", $time,
                         {depth1_wr, depth1_waddr, depth1_wdata, depth1_raddr}, exp_d1);
            end
        end
    end

    task automatic test_reset;
        rstn = 1'b0;
        enq_req = 1'b1; enq_qid = 4'd0; enq_ptr = 4'd0; enq_desc = 16'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({init_done, enq_ack, deq_ack, deq_valid, deq_empty, enq_err, head_wr, tail_wr,
             depth_wr, depth1_wr, ll_wr, pkt_desc_wr} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {init_done, enq_ack, deq_ack, deq_valid,
                     deq_empty, enq_err, head_wr, tail_wr, depth_wr, depth1_wr, ll_wr, pkt_desc_wr});
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({depth_wr, depth_waddr, depth_wdata, init_done, enq_ack} !== {1'b1, 4'(i), 4'd0, 2'b00}) begin
                failures++;
                $display("FAIL init_walk[%0d] got=%h exp=%h", i,
                         {depth_wr, depth_waddr, depth_wdata, init_done, enq_ack}, {1'b1, 4'(i), 4'd0, 2'b00});
            end
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if ({init_done, enq_ack, depth_wr} !== 3'b110) begin
            failures++;
            $display("FAIL init_done_ack got=%b exp=110", {init_done, enq_ack, depth_wr});
        end
        @(posedge clk); #1;
        enq_req = 1'b0;
    endtask

    task automatic test_enqueue;
        @(posedge clk); #1;
        enq_req = 1'b1; enq_qid = 4'd3; enq_ptr = 4'd5; enq_desc = 16'hA5A5;
        @(negedge clk);
        checks++;
        if ({enq_ack, tail_raddr, depth_raddr} !== {1'b1, 4'd3, 4'd3}) begin
            failures++;
            $display("FAIL enq1_ack got=%h exp=%h", {enq_ack, tail_raddr, depth_raddr}, {1'b1, 4'd3, 4'd3});
        end
        @(posedge clk); #1;
        enq_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({head_wr, head_waddr, head_wdata, tail_wr, tail_waddr, tail_wdata, ll_wr} !==
            {1'b1, 4'd3, 4'd5, 1'b1, 4'd3, 4'd5, 1'b0}) begin
            failures++;
            $display("FAIL enq1_head_tail got=%h", {head_wr, head_waddr, head_wdata, tail_wr, tail_waddr, tail_wdata, ll_wr});
        end
        checks++;
        if ({depth_wr, depth_waddr, depth_wdata, pkt_desc_wr, pkt_desc_waddr, pkt_desc_wdata, enq_err} !==
            {1'b1, 4'd3, 4'd1, 1'b1, 4'd5, 16'hA5A5, 1'b0}) begin
            failures++;
            $display("FAIL enq1_depth_desc got=%h", {depth_wr, depth_waddr, depth_wdata, pkt_desc_wr, pkt_desc_waddr, pkt_desc_wdata, enq_err});
        end

        @(posedge clk); #1;
        enq_req = 1'b1; enq_qid = 4'd3; enq_ptr = 4'd9; enq_desc = 16'h5A5A;
        @(negedge clk);
        checks++;
        if (enq_ack !== 1'b1) begin
            failures++;
            $display("FAIL enq2_ack got=%b exp=1", enq_ack);
        end
        @(posedge clk); #1;
        enq_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({ll_wr, ll_waddr, ll_wdata, head_wr, tail_wr, tail_waddr, tail_wdata} !==
            {1'b1, 4'd5, 4'd9, 1'b0, 1'b1, 4'd3, 4'd9}) begin
            failures++;
            $display("FAIL enq2_ll_tail got=%h", {ll_wr, ll_waddr, ll_wdata, head_wr, tail_wr, tail_waddr, tail_wdata});
        end
        checks++;
        if ({depth_wr, depth_waddr, depth_wdata, pkt_desc_wr, pkt_desc_waddr, pkt_desc_wdata} !==
            {1'b1, 4'd3, 4'd2, 1'b1, 4'd9, 16'h5A5A}) begin
            failures++;
            $display("FAIL enq2_depth_desc got=%h", {depth_wr, depth_waddr, depth_wdata, pkt_desc_wr, pkt_desc_waddr, pkt_desc_wdata});
        end
        @(posedge clk); #1;
        checks++;
        if ({head_mem[3], tail_mem[3], ll_mem[5], depth_mem[3], pd_mem[5], pd_mem[9]} !==
            {4'd5, 4'd9, 4'd9, 4'd2, 16'hA5A5, 16'h5A5A}) begin
            failures++;
            $display("FAIL enq_mem_state got=%h", {head_mem[3], tail_mem[3], ll_mem[5], depth_mem[3], pd_mem[5], pd_mem[9]});
        end
    endtask

    task automatic test_dequeue;
        logic [3:0]  ep;
        logic [15:0] ed;
        for (int k = 0; k < 2; k++) begin
            ep = (k == 0) ? 4'd5 : 4'd9;
            ed = (k == 0) ? 16'hA5A5 : 16'h5A5A;
            @(posedge clk); #1;
            deq_req = 1'b1; deq_qid = 4'd3;
            @(negedge clk);
            checks++;
            if ({deq_ack, head_raddr, depth_raddr, deq_valid} !== {1'b1, 4'd3, 4'd3, 1'b0}) begin
                failures++;
                $display("FAIL deq%0d_ack got=%h", k, {deq_ack, head_raddr, depth_raddr, deq_valid});
            end
            @(posedge clk); #1;
            deq_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({deq_valid, ll_raddr, pkt_desc_raddr} !== {1'b0, ep, ep}) begin
                failures++;
                $display("FAIL deq%0d_rd got=%h exp=%h", k, {deq_valid, ll_raddr, pkt_desc_raddr}, {1'b0, ep, ep});
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if ({deq_valid, deq_empty, deq_ptr, deq_desc} !== {1'b1, 1'b0, ep, ed}) begin
                failures++;
                $display("FAIL deq%0d_result got=%h exp=%h", k, {deq_valid, deq_empty, deq_ptr, deq_desc}, {1'b1, 1'b0, ep, ed});
            end
            checks++;
            if ({head_wr, head_waddr, depth_wr, depth_waddr, depth_wdata, tail_wr} !==
                {1'b1, 4'd3, 1'b1, 4'd3, 4'(1 - k), 1'b0}) begin
                failures++;
                $display("FAIL deq%0d_writes got=%h", k, {head_wr, head_waddr, depth_wr, depth_waddr, depth_wdata, tail_wr});
            end
            if (k == 0) begin
                checks++;
                if (head_wdata !== 4'd9) begin
                    failures++;
                    $display("FAIL deq0_new_head got=%h exp=9", head_wdata);
                end
            end
        end
        @(posedge clk); #1;
        deq_req = 1'b1; deq_qid = 4'd3;
        @(negedge clk);
        checks++;
        if (deq_ack !== 1'b1) begin
            failures++;
            $display("FAIL deq_empty_ack got=%b exp=1", deq_ack);
        end
        @(posedge clk); #1;
        deq_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({deq_valid, deq_empty, deq_ptr, head_wr, tail_wr, depth_wr, ll_wr, pkt_desc_wr} !==
            {1'b1, 1'b1, 4'd0, 5'd0}) begin
            failures++;
            $display("FAIL deq_empty_result got=%h", {deq_valid, deq_empty, deq_ptr, head_wr, tail_wr, depth_wr, ll_wr, pkt_desc_wr});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({deq_valid, deq_empty} !== 2'b00) begin
            failures++;
            $display("FAIL deq_empty_single_pulse got=%b exp=00", {deq_valid, deq_empty});
        end
    endtask

    task automatic test_back_to_back;
        int   grants = 0;
        logic exp_enq;
        logic got_enq;
        @(posedge clk); #1;
        enq_req = 1'b1; enq_qid = 4'd10; enq_ptr = 4'd1; enq_desc = 16'h1111;
        deq_req = 1'b1; deq_qid = 4'd11;
        for (int c = 0; c < 40 && grants < 6; c++) begin
            @(negedge clk);
            got_enq = enq_ack;
            if (enq_ack || deq_ack) begin
                exp_enq = (grants % 2 == 0);
                checks++;
                if ({enq_ack, deq_ack} !== {exp_enq, !exp_enq}) begin
                    failures++;
                    $display("FAIL arb_grant[%0d] got enq/deq=%b%b exp=%b%b", grants, enq_ack, deq_ack, exp_enq, !exp_enq);
                end
                grants++;
            end
            @(posedge clk); #1;
            if (got_enq) enq_ptr = enq_ptr + 4'd1;
            if (grants == 6) begin
                enq_req = 1'b0;
                deq_req = 1'b0;
            end
        end
        enq_req = 1'b0;
        deq_req = 1'b0;
        checks++;
        if (grants != 6) begin
            failures++;
            $display("FAIL arb_timeout got=%0d grants exp=6", grants);
        end
        @(posedge clk); #1;
        checks++;
        if ({depth_mem[10], head_mem[10], tail_mem[10], ll_mem[1], ll_mem[2]} !==
            {4'd3, 4'd1, 4'd3, 4'd2, 4'd3}) begin
            failures++;
            $display("FAIL arb_queue10 got=%h exp=31323", {depth_mem[10], head_mem[10], tail_mem[10], ll_mem[1], ll_mem[2]});
        end
    endtask

    task automatic test_saturation;
        @(posedge clk); #1;
        bd_depth_wr = 1'b1; bd_addr = 4'd7; bd_data = 4'd15;
        @(posedge clk); #1;
        bd_addr = 4'd8; bd_data = 4'd14;
        @(posedge clk); #1;
        bd_depth_wr = 1'b0; bd_tail_wr = 1'b1; bd_addr = 4'd8; bd_data = 4'd2;
        @(posedge clk); #1;
        bd_tail_wr = 1'b0;
        enq_req = 1'b1; enq_qid = 4'd7; enq_ptr = 4'd4; enq_desc = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (enq_ack !== 1'b1) begin
            failures++;
            $display("FAIL sat_ack got=%b exp=1", enq_ack);
        end
        @(posedge clk); #1;
        enq_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({enq_err, head_wr, tail_wr, depth_wr, ll_wr, pkt_desc_wr} !== 6'b100000) begin
            failures++;
            $display("FAIL sat_err got=%b exp=100000", {enq_err, head_wr, tail_wr, depth_wr, ll_wr, pkt_desc_wr});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (enq_err !== 1'b0) begin
            failures++;
            $display("FAIL sat_err_pulse got=%b exp=0", enq_err);
        end
        @(posedge clk); #1;
        enq_req = 1'b1; enq_qid = 4'd8; enq_ptr = 4'd6; enq_desc = 16'hCAFE;
        @(negedge clk);
        checks++;
        if (enq_ack !== 1'b1) begin
            failures++;
            $display("FAIL near_sat_ack got=%b exp=1", enq_ack);
        end
        @(posedge clk); #1;
        enq_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({enq_err, depth_wr, depth_waddr, depth_wdata, ll_wr, ll_waddr, ll_wdata, tail_wdata} !==
            {1'b0, 1'b1, 4'd8, 4'd15, 1'b1, 4'd2, 4'd6, 4'd6}) begin
            failures++;
            $display("FAIL near_sat_writes got=%h", {enq_err, depth_wr, depth_waddr, depth_wdata, ll_wr, ll_waddr, ll_wdata, tail_wdata});
        end
        @(posedge clk); #1;
        checks++;
        if ({depth_mem[7], depth_mem[8], init_done} !== {4'd15, 4'd15, 1'b1}) begin
            failures++;
            $display("FAIL sat_mem_state got=%h exp=ff1", {depth_mem[7], depth_mem[8], init_done});
        end
    endtask

    initial begin
        test_reset;
        test_enqueue;
        test_dequeue;
        test_back_to_back;
        test_saturation;
        repeat (2) @(posedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tm_qm_ctrl.md
Name: tm_qm_ctrl

Overview:
- Sequences enqueue and dequeue operations on the third-level queue-manager data-structure memories (head, tail, depth, depth1, linked list, packet descriptor).
- Arbitrates between one enqueue requester (buffer/classifier side) and one dequeue requester (scheduler side), one operation in flight at a time.
- After reset, walks every queue and zeroes its depth before accepting any traffic.

Parameters:
QUEUE_ID_NBITS, `THIRD_LVL_QUEUE_ID_NBITS, queue-id width; 2^QUEUE_ID_NBITS queues.
QUEUE_ENTRIES_NBITS, `THIRD_LVL_QUEUE_ID_NBITS, entry-pointer and depth width.

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
init_done  out  1  high once the depth-clear walk has finished
enq_req  in  1  enqueue request; held until enq_ack
enq_qid  in  QUEUE_ID_NBITS  target queue
enq_ptr  in  QUEUE_ENTRIES_NBITS  free entry supplied by the upstream allocator
enq_desc  in  sch_pkt_desc_type  descriptor to store
enq_ack  out  1  one-cycle accept pulse
enq_err  out  1  pulse; enqueue dropped because depth was saturated
deq_req  in  1  dequeue request; held until deq_ack
deq_qid  in  QUEUE_ID_NBITS  source queue
deq_ack  out  1  one-cycle accept pulse
deq_valid  out  1  one-cycle result pulse
deq_empty  out  1  qualifies deq_valid; queue was empty
deq_ptr  out  QUEUE_ENTRIES_NBITS  dequeued entry, returned to the allocator
deq_desc  out  sch_pkt_desc_type  dequeued descriptor
head_*, tail_*, depth_*, depth1_*, ll_*, pkt_desc_*  out/in  per memory  wr, raddr, waddr and wdata are outputs; rdata is an input. Widths match the queue-manager memory block.

Behaviour:
- Memories: 1-cycle registered read. A write at edge N is visible to a read issued in cycle N+1.
- Reset: FSM=INIT, init counter=0. All outputs 0, including every *_wr, init_done, acks, deq_valid, deq_empty, enq_err.
- INIT state:
  - Each cycle: depth_wr=1, depth_waddr=counter, wdata=0 (depth1 as well, see Optional Feature); counter increments.
  - After queue 2^QUEUE_ID_NBITS-1 is written: init_done=1 (sticky until reset), go to IDLE.
  - Requests are ignored and not acked during INIT.
- IDLE state:
  - If only one request is pending, grant it.
  - If both are pending, grant the type not granted last; last_grant resets to deq, so enqueue wins the first tie.
  - Grant cycle: pulse the matching ack, register qid/ptr/desc, issue reads.
  - Enqueue reads: tail_raddr=depth_raddr=qid.
  - Dequeue reads: head_raddr=depth_raddr=qid.
- ENQ_WR (1 cycle), using d=depth_rdata, t=tail_rdata:
  - d == all-ones: no writes, enq_err pulse.
  - d == 0: head[qid]=ptr, tail[qid]=ptr, depth[qid]=1, pkt_desc[ptr]=desc.
  - Otherwise: ll[t]=ptr, tail[qid]=ptr, depth[qid]=d+1, pkt_desc[ptr]=desc.
  - Then return to IDLE.
  - Enqueue latency: ack to writes = 1 cycle; occupancy 2 cycles.
- DEQ_RD (1 cycle), using h=head_rdata, d=depth_rdata:
  - d == 0: deq_valid=1, deq_empty=1, deq_ptr=0; no writes; return to IDLE.
  - Otherwise: ll_raddr=pkt_desc_raddr=h; register h and d; go to DEQ_WR.
- DEQ_WR (1 cycle):
  - head[qid]=ll_rdata, depth[qid]=d-1; tail unchanged.
  - deq_valid=1, deq_empty=0, deq_ptr=h, deq_desc=pkt_desc_rdata.
  - Return to IDLE.
  - When d==1, head takes a stale ll value; this is don't-care because depth=0.
  - Dequeue latency: ack to deq_valid = 2 cycles (nonempty) or 1 cycle (empty).
- Operations never overlap, so back-to-back operations on the same queue need no forwarding.
- Depth arithmetic is unsigned QUEUE_ENTRIES_NBITS and never wraps (saturation check above).
- Reset asserted mid-operation aborts it; memory contents are unspecified until the INIT walk completes.

Optional Feature:
- Macro: TM_QM_CTRL_DEPTH1_MIRROR_EN.
- Defined: every depth write (INIT, ENQ_WR, DEQ_WR) is duplicated on depth1_* with the same address and data, giving the scheduler a private read copy. depth1_raddr is driven 0.
- Undefined: depth1_wr, depth1_waddr, depth1_wdata and depth1_raddr are tied to 0; depth1_rdata is ignored.

Test Plan:
- Reset release with QUEUE_ID_NBITS=4 -> 16 consecutive depth writes of 0, then init_done=1; enq_req held throughout is acked only after init_done.
- Enqueue ptr 5 then 9 to queue 3 -> head[3]=5, tail[3]=9, ll[5]=9, depth[3]=2; pkt_desc[5] and pkt_desc[9] hold their descriptors.
- Two dequeues of queue 3 -> deq_ptr 5 then 9 with matching descriptors, depth goes 1 then 0; a third dequeue -> deq_valid with deq_empty=1 one cycle after ack, no writes.
- enq_req and deq_req asserted together continuously for 6 grants -> acks alternate enq, deq, enq, ...; enqueue granted first.
- Force depth[7]=all-ones, then enqueue to queue 7 -> enq_err pulse, no memory writes.
- With TM_QM_CTRL_DEPTH1_MIRROR_EN defined -> depth1 writes match depth writes cycle-for-cycle; undefined -> depth1_wr stays 0.
